icache_fill_server: RTL and testbench
=====================================

// Module: icache_fill_server
// PURPOSE
//  Memory-controller end of the icache fill interface: serves icache misses from NCPU cores.
//  Each core drives iREN/iaddr and waits on iwait/iload.
//  Arbitrates round-robin onto one RAM read port and returns fill data to the granted core.
//  Sits in the memory controller between the per-core icaches and the shared RAM.
// PARAMETERS
//  NCPU     2   number of icache requesters (>=1)
//  TIMEOUT  64  cycles to wait for ramready before abort (used only with ICACHE_FILL_TIMEOUT_EN)
// PORTS
//  CLK          in   1        clock, rising edge
//  RST          in   1        reset, synchronous, active-high
//  iREN         in   NCPU     per-core fill request (held while miss outstanding)
//  iaddr        in   NCPU*32  per-core word address (word_t per core)
//  iwait        out  NCPU     per-core wait; 0 only in the data-return cycle
//  iload        out  NCPU*32  per-core fill data (word_t per core)
//  ramREN       out  1        RAM read enable
//  ramaddr      out  32       RAM read address
//  ramload      in   32       RAM read data, valid when ramready=1
//  ramready     in   1        RAM data-valid pulse, one cycle
//  timeout_err  out  1        one-cycle pulse on RAM timeout abort
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, iwait=all 1, iload=all 0, ramREN=0, ramaddr=0, timeout_err=0.
//  FSM IDLE:
//   - If any iREN is high: grant the first requester at or after rr_ptr (wrapping modulo NCPU).
//   - Latch gnt_id and gaddr=iaddr[gnt_id]; go to REQ.
//  FSM REQ:
//   - ramREN=1, ramaddr=gaddr.
//   - On ramready: latch ramload and go to RESP.
//   - ramready in the same cycle as entry to REQ is legal (1-cycle RAM).
//  FSM RESP: one cycle, ramREN=0.
//   - If iREN[gnt_id]=1 and iaddr[gnt_id]==gaddr: iwait[gnt_id]=0 and iload[gnt_id]=latched data.
//   - Otherwise the data is discarded and all iwait stay 1.
//   - In both cases rr_ptr=(gnt_id+1)%NCPU, then go to IDLE.
//  Output rules:
//   - iwait[k]=1 in every cycle other than core k's RESP hit, including when iREN[k]=0.
//     The icache writes its block on !iwait, so this is mandatory.
//   - iload[k] is 0 whenever iwait[k]=1.
//  Latency: request seen in IDLE -> earliest iwait low 2 cycles later (1-cycle RAM).
//  Back-to-back: IDLE is always visited between grants. Minimum 3 cycles per fill.
//  Simultaneous requests: rr_ptr decides; a loser holds iREN and is served next, so no starvation.
//  Requester drops iREN or changes iaddr mid-fill:
//   - The RAM read still completes (no abort on the RAM side).
//   - The result is discarded in RESP. The core re-requests later.
//  RST while in REQ/RESP: return to IDLE next cycle with reset values.
//   - A pending ramready is ignored while in IDLE.
// CONFIGURATION
//  ICACHE_FILL_TIMEOUT_EN defined:
//   - A counter runs in REQ. Reaching TIMEOUT cycles with no ramready forces ramREN=0.
//   - timeout_err pulses 1 cycle, rr_ptr advances, state goes to IDLE, and iwait stays 1.
//  Undefined: no counter; REQ waits for ramready forever; timeout_err is tied 0.
// STRUCTURE
//  cpu_types_pkg additions:
//   - ifill_state_t enum {IDLE, REQ, RESP}
//   - constant IFILL_TIMEOUT_DEFAULT=64
//   - word_t is reused for all data and addresses.
//  Sub-module rr_arbiter #(N) (req[N], ptr[$clog2(N)] -> gnt_valid, gnt_id):
//   - Combinational priority rotate.
//   - The fill server owns rr_ptr.
// TESTING
//  1. Reset: hold RST 2 cycles with iREN=2'b11 -> iwait=2'b11, ramREN=0, iload=0 throughout.
//  2. Single fill: core0 iREN=1, iaddr=0x100; RAM returns 0xDEADBEEF 1 cycle after ramREN.
//     -> ramaddr=0x100; then iwait[0]=0 for exactly 1 cycle with iload[0]=0xDEADBEEF; iwait[1]=1 always.
//  3. Contention: both cores request (0x40, 0x80) from rr_ptr=0.
//     -> core0 is served first, then core1; the next tie is won by core0 again.
//  4. Abort: core1 changes iaddr 0x80->0x84 while in REQ.
//     -> RAM read of 0x80 completes, iwait[1] stays 1, and a new fill of 0x84 follows.
//  5. Reset mid-fill: RST asserted in REQ.
//     -> ramREN=0 next cycle, state IDLE; a late ramready causes no iwait drop.
//  6. With ICACHE_FILL_TIMEOUT_EN, TIMEOUT=8: ramready never arrives.
//     -> timeout_err pulses at REQ cycle 8, ramREN drops, and the other core is granted next.

Source files
------------

// File: rtl/icache_fill_server_pkg.sv
// rtl/icache_fill_server_pkg.sv - shared types and constants for the icache fill server
//
// Purpose: word type, fill FSM state enum, default RAM timeout and the
// round-robin pointer advance helper used by icache_fill_server.
// Ports: none (package).
package icache_fill_server_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } ifill_state_t;

  localparam int IFILL_TIMEOUT_DEFAULT = 64;

  // Next round-robin start position after serving requester id out of n.
  function automatic int ifill_next_ptr(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/icache_fill_server_rr_arbiter.sv
// rtl/icache_fill_server_rr_arbiter.sv - combinational rotating-priority arbiter
//
// Purpose: grants the first asserted request at or after ptr, wrapping modulo N.
// Ports:
//   req        in   N    request vector
//   ptr        in   PW   round-robin start position (owned by the caller)
//   gnt_valid  out  1    any request asserted
//   gnt_id     out  PW   index of the granted requester
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          gnt_valid,
  output logic [PW-1:0] gnt_id
);

  // Scan from the farthest offset down to offset 0 so the requester closest
  // to ptr is the last one written and therefore wins.
  always_comb begin : p_rotate
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[PW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_id    = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/icache_fill_server.sv
// rtl/icache_fill_server.sv - memory-controller side server for per-core icache fills
//
// Purpose: arbitrates icache miss requests from NCPU cores round-robin onto a
// single RAM read port and returns the fill word to the granted core.
// Optional feature macro: ICACHE_FILL_TIMEOUT_EN (abort a RAM read after TIMEOUT cycles).
// Ports:
//   CLK          in   1        clock, rising edge
//   RST          in   1        synchronous active-high reset
//   iREN         in   NCPU     per-core fill request, held while the miss is outstanding
//   iaddr        in   NCPU*32  per-core word address
//   iwait        out  NCPU     per-core wait, low only in that core's data-return cycle
//   iload        out  NCPU*32  per-core fill data, zero while iwait is high
//   ramREN       out  1        RAM read enable
//   ramaddr      out  32       RAM read address
//   ramload      in   32       RAM read data, valid with ramready
//   ramready     in   1        RAM data-valid pulse
//   timeout_err  out  1        one-cycle pulse when a RAM read is abandoned
module icache_fill_server
  import icache_fill_server_pkg::*;
#(
  parameter int NCPU    = 2,
  parameter int TIMEOUT = IFILL_TIMEOUT_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCPU-1:0]      iREN,
  input  word_t [NCPU-1:0]     iaddr,
  output logic [NCPU-1:0]      iwait,
  output word_t [NCPU-1:0]     iload,
  output logic                 ramREN,
  output word_t                ramaddr,
  input  word_t                ramload,
  input  logic                 ramready,
  output logic                 timeout_err
);

  localparam int PW = (NCPU > 1) ? $clog2(NCPU) : 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]    r_state;
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] r_gnt_id;
  word_t         r_gaddr;
  word_t         r_data;

  logic          w_gnt_valid;
  logic [PW-1:0] w_gnt_id;
  logic [PW-1:0] w_next_ptr;
  logic          w_hit;
  logic          w_timeout;

  rr_arbiter #(.N(NCPU)) u_arb (
    .req       (iREN),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_next_ptr = PW'(ifill_next_ptr(int'(r_gnt_id), NCPU));

  // The fill is only delivered if the core is still asking for the same word;
  // a dropped or redirected request turns the return cycle into a discard.
  assign w_hit = iREN[r_gnt_id] && (iaddr[r_gnt_id] == r_gaddr);

`ifdef ICACHE_FILL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_tmo_cnt;

  // r_tmo_cnt holds the number of REQ cycles already completed, so the
  // abort fires in the TIMEOUT-th REQ cycle when data still has not arrived.
  assign w_timeout = (r_state == ST_REQ) && !ramready && (r_tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST || (r_state != ST_REQ)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;

  // TIMEOUT has no effect without the abort counter.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
      r_gaddr  <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_id <= w_gnt_id;
            r_gaddr  <= iaddr[w_gnt_id];
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ramready) begin
            r_data  <= ramload;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        ST_RESP: begin
          r_rr_ptr <= w_next_ptr;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced to their idle values while RST is high so a core can
  // never see a spurious !iwait during reset.
  always_comb begin
    iwait       = '1;
    iload       = '0;
    ramREN      = 1'b0;
    ramaddr     = '0;
    timeout_err = 1'b0;
    if (!RST) begin
      if (r_state == ST_REQ) begin
        ramREN      = 1'b1;
        ramaddr     = r_gaddr;
        timeout_err = w_timeout;
      end
      if ((r_state == ST_RESP) && w_hit) begin
        iwait[r_gnt_id] = 1'b0;
        iload[r_gnt_id] = r_data;
      end
    end
  end

endmodule

// File: tb/tb_icache_fill_server.sv
// tb/tb_icache_fill_server.sv - self-checking bench for icache_fill_server
module tb_icache_fill_server;
  import icache_fill_server_pkg::*;

  localparam int NCPU = 2;
`ifdef ICACHE_FILL_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic [1:0]   iREN;
  word_t [1:0]  iaddr;
  logic [1:0]   iwait;
  word_t [1:0]  iload;
  logic         ramREN;
  word_t        ramaddr;
  word_t        ramload;
  logic         ramready;
  logic         timeout_err;

  int n_pass;
  int n_total;
  bit ram_auto;
  int ram_lat;
  int ram_wait;

  always #5 CLK = ~CLK;

  icache_fill_server #(.NCPU(NCPU), .TIMEOUT(TMO)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .iwait       (iwait),
    .iload       (iload),
    .ramREN      (ramREN),
    .ramaddr     (ramaddr),
    .ramload     (ramload),
    .ramready    (ramready),
    .timeout_err (timeout_err)
  );

  // RAM contents: 0x100 maps to 0xDEADBEEF.
  function automatic word_t mem_f(input word_t a);
    return a ^ 32'hDEAD_BFEF;
  endfunction

  // Advance one clock, then act as the RAM: answer ram_lat cycles after ramREN is seen.
  task automatic cycle();
    @(posedge CLK);
    #1;
    ramready = 1'b0;
    ramload  = $urandom;
    if (ram_auto && ramREN) begin
      if (ram_wait >= ram_lat) begin
        ramready = 1'b1;
        ramload  = mem_f(ramaddr);
        ram_wait = 0;
      end else begin
        ram_wait++;
      end
    end else begin
      ram_wait = 0;
    end
  endtask

  task automatic test_reset();
    RST      = 1'b1;
    iREN     = 2'b11;
    iaddr[0] = $urandom;
    iaddr[1] = $urandom;
    for (int c = 0; c < 2; c++) begin
      cycle();
      n_total++; if (iwait !== 2'b11) $display("FAIL reset_iwait: got %b expected 11", iwait); else n_pass++;
      n_total++; if (ramREN !== 1'b0) $display("FAIL reset_ramREN: got %b expected 0", ramREN); else n_pass++;
      n_total++; if (iload !== '0) $display("FAIL reset_iload: got %h expected 0", iload); else n_pass++;
      n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); else n_pass++;
    end
    RST  = 1'b0;
    iREN = 2'b00;
    cycle();
    n_total++; if (ramREN !== 1'b0) $display("FAIL idle_ramREN: got %b expected 0", ramREN); else n_pass++;
  endtask

  task automatic test_single_fill();
    ram_auto = 1'b1;
    ram_lat  = 0;
    iaddr[0] = 32'h100;
    iaddr[1] = $urandom;
    iREN     = 2'b01;
    cycle();
    n_total++; if (ramREN !== 1'b1) $display("FAIL single_ramREN: got %b expected 1", ramREN); else n_pass++;
    n_total++; if (ramaddr !== 32'h100) $display("FAIL single_ramaddr: got %h expected 00000100", ramaddr); else n_pass++;
    n_total++; if (iwait !== 2'b11) $display("FAIL single_wait_req: got %b expected 11", iwait); else n_pass++;
    cycle();
    n_total++; if (iwait !== 2'b10) $display("FAIL single_wait_resp: got %b expected 10", iwait); else n_pass++;
    n_total++; if (iload[0] !== 32'hDEADBEEF) $display("FAIL single_iload0: got %h expected deadbeef", iload[0]); else n_pass++;
    n_total++; if (iload[1] !== 32'h0) $display("FAIL single_iload1: got %h expected 0", iload[1]); else n_pass++;
    iREN = 2'b00;
    cycle();
    n_total++; if (iwait !== 2'b11) $display("FAIL single_wait_after: got %b expected 11", iwait); else n_pass++;
    n_total++; if (ramREN !== 1'b0) $display("FAIL single_ramREN_after: got %b expected 0", ramREN); else n_pass++;
  endtask

  task automatic test_contention();
    int    served[$];
    word_t gaddrs[$];
    bit    prev_ren;
    bit    found;
    RST  = 1'b1;
    iREN = 2'b00;
    cycle();
    RST      = 1'b0;
    ram_auto = 1'b1;
    ram_lat  = 0;
    iaddr[0] = 32'h40;
    iaddr[1] = 32'h80;
    iREN     = 2'b11;
    prev_ren = 1'b0;
    for (int c = 0; c < 20 && served.size() < 2; c++) begin
      cycle();
      if (ramREN && !prev_ren) gaddrs.push_back(ramaddr);
      prev_ren = ramREN;
      for (int j = 0; j < 2; j++) begin
        if (!iwait[j]) begin
          n_total++; if (iload[j] !== mem_f(iaddr[j])) $display("FAIL contention_data%0d: got %h expected %h", j, iload[j], mem_f(iaddr[j])); else n_pass++;
          served.push_back(j);
          iREN[j] = 1'b0;
        end
      end
    end
    n_total++;
    if (served.size() != 2 || served[0] != 0 || served[1] != 1)
      $display("FAIL contention_order: got %0d fills %p expected [0,1]", served.size(), served);
    else n_pass++;
    n_total++;
    if (gaddrs.size() < 2 || gaddrs[0] !== 32'h40 || gaddrs[1] !== 32'h80)
      $display("FAIL contention_ramaddr: got %p expected [40,80]", gaddrs);
    else n_pass++;
    iREN  = 2'b11;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      cycle();
      if (ramREN) found = 1'b1;
    end
    n_total++; if (!found || ramaddr !== 32'h40) $display("FAIL contention_retie: got found=%0b ramaddr=%h expected 00000040", found, ramaddr); else n_pass++;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      cycle();
      if (!iwait[0]) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL contention_retie_fill: got no fill expected core0 fill"); else n_pass++;
    iREN = 2'b00;
    cycle();
    cycle();
  endtask

  task automatic test_abort();
    bit found;
    bit bad_addr;
    ram_auto = 1'b1;
    ram_lat  = 2;
    iaddr[1] = 32'h80;
    iREN     = 2'b10;
    cycle();
    n_total++; if (ramREN !== 1'b1 || ramaddr !== 32'h80) $display("FAIL abort_req: got ren=%b addr=%h expected ren=1 addr=00000080", ramREN, ramaddr); else n_pass++;
    iaddr[1] = 32'h84;
    found    = 1'b0;
    bad_addr = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cycle();
      if (!ramREN) found = 1'b1;
      else if (ramaddr !== 32'h80) bad_addr = 1'b1;
    end
    n_total++; if (!found || bad_addr) $display("FAIL abort_read_0x80: got done=%0b addr_changed=%0b expected 1/0", found, bad_addr); else n_pass++;
    n_total++; if (iwait !== 2'b11) $display("FAIL abort_discard: got %b expected 11", iwait); else n_pass++;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      cycle();
      if (ramREN) found = 1'b1;
    end
    n_total++; if (!found || ramaddr !== 32'h84) $display("FAIL abort_refill_addr: got found=%0b addr=%h expected 00000084", found, ramaddr); else n_pass++;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cycle();
      if (!iwait[1]) found = 1'b1;
    end
    n_total++; if (!found || iload[1] !== mem_f(32'h84)) $display("FAIL abort_refill_data: got found=%0b data=%h expected %h", found, iload[1], mem_f(32'h84)); else n_pass++;
    iREN = 2'b00;
    cycle();
  endtask

  task automatic test_reset_mid_fill();
    bit found;
    ram_auto = 1'b0;
    iaddr[0] = 32'h200;
    iREN     = 2'b01;
    cycle();
    n_total++; if (ramREN !== 1'b1) $display("FAIL midrst_req: got %b expected 1", ramREN); else n_pass++;
    RST = 1'b1;
    cycle();
    n_total++; if (ramREN !== 1'b0) $display("FAIL midrst_ramREN: got %b expected 0", ramREN); else n_pass++;
    RST      = 1'b0;
    iREN     = 2'b00;
    ramready = 1'b1;
    ramload  = mem_f(32'h200);
    cycle();
    n_total++; if (iwait !== 2'b11 || ramREN !== 1'b0) $display("FAIL midrst_late_ready: got wait=%b ren=%b expected 11/0", iwait, ramREN); else n_pass++;
    cycle();
    n_total++; if (iwait !== 2'b11) $display("FAIL midrst_late_ready2: got %b expected 11", iwait); else n_pass++;
    ram_auto = 1'b1;
    ram_lat  = 1;
    iREN     = 2'b01;
    found    = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cycle();
      if (!iwait[0]) found = 1'b1;
    end
    n_total++; if (!found || iload[0] !== mem_f(32'h200)) $display("FAIL midrst_refill: got found=%0b data=%h expected %h", found, iload[0], mem_f(32'h200)); else n_pass++;
    iREN = 2'b00;
    cycle();
  endtask

`ifdef ICACHE_FILL_TIMEOUT_EN
  task automatic test_timeout();
    RST      = 1'b1;
    iREN     = 2'b00;
    ram_auto = 1'b0;
    cycle();
    RST      = 1'b0;
    iaddr[0] = 32'h300;
    iaddr[1] = 32'h304;
    iREN     = 2'b11;
    cycle();
    for (int n = 1; n <= TMO; n++) begin
      n_total++; if (timeout_err !== 1'(n == TMO)) $display("FAIL timeout_pulse_c%0d: got %b expected %b", n, timeout_err, (n == TMO)); else n_pass++;
      n_total++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) $display("FAIL timeout_req_c%0d: got ren=%b addr=%h expected 1/00000300", n, ramREN, ramaddr); else n_pass++;
      if (n < TMO) cycle();
    end
    cycle();
    n_total++; if (ramREN !== 1'b0 || iwait !== 2'b11 || timeout_err !== 1'b0) $display("FAIL timeout_after: got ren=%b wait=%b err=%b expected 0/11/0", ramREN, iwait, timeout_err); else n_pass++;
    cycle();
    n_total++; if (ramREN !== 1'b1 || ramaddr !== 32'h304) $display("FAIL timeout_next_grant: got ren=%b addr=%h expected 1/00000304", ramREN, ramaddr); else n_pass++;
    RST  = 1'b1;
    iREN = 2'b00;
    cycle();
    RST = 1'b0;
    cycle();
  endtask
`endif

  // Transaction-level reference: one fill in flight at a time, winner is the
  // first requester at or after the pointer, data is delivered only if the
  // core still asks for the same word when the RAM data comes back.
  task automatic test_random();
    bit          pend [2];
    word_t       paddr [2];
    int          m_phase;
    int          m_ptr;
    int          m_g;
    word_t       m_ga;
    logic [1:0]  e_ren;
    word_t [1:0] e_addr;
    logic        e_rdy;
    logic [1:0]  exp_wait;
    word_t [1:0] exp_load;
    RST      = 1'b1;
    iREN     = 2'b00;
    ram_auto = 1'b1;
    ram_lat  = 0;
    cycle();
    RST     = 1'b0;
    pend    = '{1'b0, 1'b0};
    paddr   = '{32'h0, 32'h0};
    m_phase = 0;
    m_ptr   = 0;
    m_g     = 0;
    m_ga    = '0;
    for (int c = 0; c < 2000; c++) begin
      e_ren  = iREN;
      e_addr = iaddr;
      e_rdy  = ramready;
      cycle();
      if (m_phase == 0) begin
        if (e_ren != 2'b00) begin
          m_g     = e_ren[m_ptr] ? m_ptr : (m_ptr + 1) % 2;
          m_ga    = e_addr[m_g];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (e_rdy) m_phase = 2;
      end else begin
        m_ptr   = (m_g + 1) % 2;
        m_phase = 0;
      end
      exp_wait = 2'b11;
      exp_load = '0;
      if (m_phase == 2 && iREN[m_g] && iaddr[m_g] == m_ga) begin
        exp_wait[m_g] = 1'b0;
        exp_load[m_g] = mem_f(m_ga);
      end
      n_total++; if (iwait !== exp_wait) $display("FAIL rand_iwait c%0d: got %b expected %b", c, iwait, exp_wait); else n_pass++;
      n_total++; if (iload !== exp_load) $display("FAIL rand_iload c%0d: got %h expected %h", c, iload, exp_load); else n_pass++;
      n_total++; if (ramREN !== 1'(m_phase == 1)) $display("FAIL rand_ramREN c%0d: got %b expected %b", c, ramREN, (m_phase == 1)); else n_pass++;
      if (m_phase == 1) begin
        n_total++; if (ramaddr !== m_ga) $display("FAIL rand_ramaddr c%0d: got %h expected %h", c, ramaddr, m_ga); else n_pass++;
      end
      n_total++; if (timeout_err !== 1'b0) $display("FAIL rand_timeout_err c%0d: got %b expected 0", c, timeout_err); else n_pass++;
      for (int k = 0; k < 2; k++) begin
        if (pend[k] && !iwait[k]) pend[k] = 1'b0;
        if (pend[k]) begin
          if ($urandom_range(0, 29) == 0) begin
            if ($urandom_range(0, 1) == 0) pend[k] = 1'b0;
            else paddr[k] = paddr[k] + 32'd4;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          pend[k]  = 1'b1;
          paddr[k] = word_t'($urandom_range(0, 1023)) << 2;
        end
        iREN[k]  = pend[k];
        iaddr[k] = pend[k] ? paddr[k] : word_t'($urandom);
      end
      ram_lat = $urandom_range(0, 3);
    end
    iREN = 2'b00;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    ram_auto = 1'b0;
    ram_lat  = 0;
    ram_wait = 0;
    ramready = 1'b0;
    ramload  = '0;
    RST      = 1'b1;
    iREN     = 2'b00;
    iaddr    = '0;
    test_reset();
    test_single_fill();
    test_contention();
    test_abort();
    test_reset_mid_fill();
`ifdef ICACHE_FILL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
